// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit path among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to abort a transfer with err after TIMEOUT_CYCLES without ready.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic [DATA_WIDTH-1:0]         write_data_in,
  output logic                          TX_detect,
  input  logic                          ready,
  input  logic                          error,
  output logic                          tx_active
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e                 state_q,  state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [NUM_REQ-1:0]     gnt_q,    gnt_d;
  logic [NUM_REQ-1:0]     done_q,   done_d;
  logic [NUM_REQ-1:0]     err_q,    err_d;
  logic [DATA_WIDTH-1:0]  data_q,   data_d;
  logic                   tx_q,     tx_d;
  logic                   active_q, active_d;
  logic [IDX_W-1:0]       arb_idx;
  logic                   finish;
  logic                   finish_err;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]            wait_cnt_q, wait_cnt_d;
  logic                   timed_out;

  assign timed_out = (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  // First pending requester at or above rr_ptr, wrapping.
  always_comb begin
    arb_idx = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        arb_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // ready takes priority over a same-cycle timeout so err reflects the UART.
  always_comb begin
    finish     = ready;
    finish_err = error;
`ifdef UART_ARB_TIMEOUT_EN
    if (!ready && timed_out) begin
      finish     = 1'b1;
      finish_err = 1'b1;
    end
`endif
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    data_d   = data_q;
    tx_d     = tx_q;
    active_d = active_q;
`ifdef UART_ARB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          winner_d         = arb_idx;
          gnt_d            = '0;
          gnt_d[arb_idx]   = 1'b1;
          data_d           = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          tx_d             = 1'b1;
          active_d         = 1'b1;
          state_d          = SEND;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt_d       = '0;
`endif
        end
      end
      SEND: begin
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        if (finish) begin
          tx_d             = 1'b0;
          done_d[winner_q] = 1'b1;
          err_d[winner_q]  = finish_err;
          state_d          = GAP;
        end
      end
      GAP: begin
        gnt_d    = '0;
        active_d = 1'b0;
        rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b0;
      active_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      active_q <= active_d;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign err           = err_q;
  assign write_data_in = data_q;
  assign TX_detect     = tx_q;
  assign tx_active     = active_q;

endmodule
